// File: rtl/cross_centers_grid.sv
// Finder-center locator: walks candidate pixels zone by zone, qualifies each zone
// by black-pixel ratio and reports floored black centroids through a serial divider.
module cross_centers_grid #(
  parameter int WIDTH        = 480,
  parameter int HEIGHT       = 480,
  parameter int ZONES_X      = 3,
  parameter int ZONES_Y      = 3,
  parameter int NUM_CENTERS  = 3,
  parameter int READ_LATENCY = 2,
  parameter int THRESH_NUM   = 3,
  parameter int THRESH_SHIFT = 2,
  localparam int CW  = $clog2((WIDTH > HEIGHT) ? WIDTH : HEIGHT),
  localparam int KW  = $clog2(WIDTH * HEIGHT + 1),
  localparam int AW  = $clog2(WIDTH * HEIGHT),
  localparam int FW  = $clog2(NUM_CENTERS + 1),
  localparam int BXW = (ZONES_X > 1) ? (ZONES_X - 1) * CW : 1,
  localparam int BYW = (ZONES_Y > 1) ? (ZONES_Y - 1) * CW : 1
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      start_in,
  input  logic [WIDTH-1:0]          horz_patterns,
  input  logic [HEIGHT-1:0]         vert_patterns,
  input  logic [BXW-1:0]            bound_x,
  input  logic [BYW-1:0]            bound_y,
  input  logic                      pixel_in,
  output logic [AW-1:0]             addr_out,
  output logic [NUM_CENTERS*CW-1:0] centers_x,
  output logic [NUM_CENTERS*CW-1:0] centers_y,
  output logic [FW-1:0]             centers_found,
  output logic                      centers_valid,
  output logic                      centers_error,
  output logic                      busy_out
);

  localparam int SW  = CW + KW;
  localparam int RW  = KW + THRESH_SHIFT + $clog2(THRESH_NUM + 1);
  localparam int BW  = CW + 1;
  localparam int ZXW = $clog2(ZONES_X + 1);
  localparam int ZYW = $clog2(ZONES_Y + 1);
  localparam int WCW = $clog2(READ_LATENCY) + 1;
  localparam int DCW = $clog2(2 * SW);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SCAN    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_SAMPLE  = 3'd3,
    ST_QUALIFY = 3'd4,
    ST_DIVIDE  = 3'd5,
    ST_NEXT    = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  state_t          state_r;
  logic [BW-1:0]   bx_r [0:ZONES_X];
  logic [BW-1:0]   by_r [0:ZONES_Y];
  logic [ZXW-1:0]  zx_r;
  logic [ZYW-1:0]  zy_r;
  logic [CW-1:0]   x_r, y_r, qx_r;
  logic [WCW-1:0]  wait_cnt_r;
  logic [DCW-1:0]  div_cnt_r;
  logic            pix_r;
  logic [KW-1:0]   total_r, black_r, rem_r;
  logic [SW-1:0]   sum_x_r, sum_y_r, dq_r;

  logic [ZXW-1:0]  zx1_s, nzx_s;
  logic [ZYW-1:0]  zy1_s, nzy_s;
  logic [BW-1:0]   x_lo_s, x_hi_s, y_lo_s, y_hi_s;
  logic            zone_empty_s, last_x_s, last_y_s, zone_end_s, last_zone_s, candidate_s;
  logic [CW-1:0]   nx_s, ny_s, nx_lo_s, ny_lo_s;
  logic [RW-1:0]   lhs_s, rhs_s;
  logic            ratio_pass_s, ge_s;
  logic [KW:0]     trial_s, diff_s;
  logic [KW-1:0]   rem_next_s;
  logic [SW-1:0]   q_next_s;

  // Bounds larger than the frame collapse onto the frame edge, turning that zone empty.
  function automatic logic [BW-1:0] clamp_bound(input logic [CW-1:0] b, input int lim);
    if (BW'(b) > BW'(lim)) begin
      clamp_bound = BW'(lim);
    end else begin
      clamp_bound = BW'(b);
    end
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [CW-1:0] px, input logic [CW-1:0] py);
    addr_of = AW'(py) * AW'(WIDTH) + AW'(px);
  endfunction

  // Zone geometry, in-zone stepping, ratio test and one restoring-divide step.
  always_comb begin
    zx1_s        = zx_r + ZXW'(1);
    zy1_s        = zy_r + ZYW'(1);
    x_lo_s       = bx_r[zx_r];
    x_hi_s       = bx_r[zx1_s];
    y_lo_s       = by_r[zy_r];
    y_hi_s       = by_r[zy1_s];
    zone_empty_s = (x_hi_s <= x_lo_s) || (y_hi_s <= y_lo_s);
    last_x_s     = ({1'b0, x_r} + BW'(1)) >= x_hi_s;
    last_y_s     = ({1'b0, y_r} + BW'(1)) >= y_hi_s;
    zone_end_s   = last_x_s && last_y_s;
    last_zone_s  = (zx_r == ZXW'(ZONES_X - 1)) && (zy_r == ZYW'(ZONES_Y - 1));
    candidate_s  = horz_patterns[x_r] && vert_patterns[y_r];
    if (!last_x_s) begin
      nx_s = x_r + CW'(1);
      ny_s = y_r;
    end else begin
      nx_s = x_lo_s[CW-1:0];
      ny_s = y_r + CW'(1);
    end
    if (zx_r == ZXW'(ZONES_X - 1)) begin
      nzx_s = '0;
      nzy_s = zy1_s;
    end else begin
      nzx_s = zx1_s;
      nzy_s = zy_r;
    end
    nx_lo_s      = bx_r[nzx_s][CW-1:0];
    ny_lo_s      = by_r[nzy_s][CW-1:0];
    lhs_s        = RW'(black_r) << THRESH_SHIFT;
    rhs_s        = RW'(total_r) * RW'(THRESH_NUM);
    ratio_pass_s = lhs_s > rhs_s;
    trial_s      = {rem_r, dq_r[SW-1]};
    diff_s       = trial_s - {1'b0, black_r};
    ge_s         = trial_s >= {1'b0, black_r};
    rem_next_s   = ge_s ? diff_s[KW-1:0] : trial_s[KW-1:0];
    q_next_s     = {dq_r[SW-2:0], ge_s};
  end

  // Control FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_r       <= ST_IDLE;
      for (int k = 0; k <= ZONES_X; k++) bx_r[k] <= '0;
      for (int k = 0; k <= ZONES_Y; k++) by_r[k] <= '0;
      zx_r          <= '0;
      zy_r          <= '0;
      x_r           <= '0;
      y_r           <= '0;
      qx_r          <= '0;
      wait_cnt_r    <= '0;
      div_cnt_r     <= '0;
      pix_r         <= 1'b0;
      total_r       <= '0;
      black_r       <= '0;
      rem_r         <= '0;
      sum_x_r       <= '0;
      sum_y_r       <= '0;
      dq_r          <= '0;
      addr_out      <= '0;
      centers_x     <= '0;
      centers_y     <= '0;
      centers_found <= '0;
      centers_valid <= 1'b0;
      centers_error <= 1'b0;
      busy_out      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          centers_valid <= 1'b0;
          centers_error <= 1'b0;
          if (start_in) begin
            bx_r[0]       <= '0;
            by_r[0]       <= '0;
            for (int k = 1; k < ZONES_X; k++) bx_r[k] <= clamp_bound(bound_x[(k-1)*CW +: CW], WIDTH);
            for (int k = 1; k < ZONES_Y; k++) by_r[k] <= clamp_bound(bound_y[(k-1)*CW +: CW], HEIGHT);
            bx_r[ZONES_X] <= BW'(WIDTH);
            by_r[ZONES_Y] <= BW'(HEIGHT);
            zx_r          <= '0;
            zy_r          <= '0;
            x_r           <= '0;
            y_r           <= '0;
            addr_out      <= '0;
            total_r       <= '0;
            black_r       <= '0;
            sum_x_r       <= '0;
            sum_y_r       <= '0;
            centers_x     <= '0;
            centers_y     <= '0;
            centers_found <= '0;
            busy_out      <= 1'b1;
            state_r       <= ST_SCAN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (zone_empty_s) begin
            state_r <= ST_QUALIFY;
          end else if (candidate_s) begin
            wait_cnt_r <= '0;
            state_r    <= ST_WAIT;
          end else if (zone_end_s) begin
            state_r <= ST_QUALIFY;
          end else begin
            x_r      <= nx_s;
            y_r      <= ny_s;
            addr_out <= addr_of(nx_s, ny_s);
          end
        end
        ST_WAIT: begin
          // Last wait cycle is READ_LATENCY cycles after the address first appeared.
          if (wait_cnt_r == WCW'(READ_LATENCY - 1)) begin
            pix_r   <= pixel_in;
            state_r <= ST_SAMPLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + WCW'(1);
          end
        end
        ST_SAMPLE: begin
          total_r <= total_r + KW'(1);
          if (!pix_r) begin
            black_r <= black_r + KW'(1);
            sum_x_r <= sum_x_r + SW'(x_r);
            sum_y_r <= sum_y_r + SW'(y_r);
          end else begin
            black_r <= black_r;
          end
          if (zone_end_s) begin
            state_r <= ST_QUALIFY;
          end else begin
            x_r      <= nx_s;
            y_r      <= ny_s;
            addr_out <= addr_of(nx_s, ny_s);
            state_r  <= ST_SCAN;
          end
        end
        ST_QUALIFY: begin
          if ((black_r != '0) && ratio_pass_s) begin
            dq_r      <= sum_x_r;
            rem_r     <= '0;
            div_cnt_r <= '0;
            state_r   <= ST_DIVIDE;
          end else begin
            state_r <= ST_NEXT;
          end
        end
        ST_DIVIDE: begin
          div_cnt_r <= div_cnt_r + DCW'(1);
          // First SW steps yield x, the second SW steps yield y.
          if (div_cnt_r == DCW'(SW - 1)) begin
            qx_r  <= q_next_s[CW-1:0];
            dq_r  <= sum_y_r;
            rem_r <= '0;
          end else begin
            dq_r  <= q_next_s;
            rem_r <= rem_next_s;
          end
          if (div_cnt_r == DCW'(2 * SW - 1)) begin
            for (int k = 0; k < NUM_CENTERS; k++) begin
              if (centers_found == FW'(k)) begin
                centers_x[k*CW +: CW] <= qx_r;
                centers_y[k*CW +: CW] <= q_next_s[CW-1:0];
              end else begin
                centers_x[k*CW +: CW] <= centers_x[k*CW +: CW];
              end
            end
            centers_found <= centers_found + FW'(1);
            state_r       <= ST_NEXT;
          end else begin
            state_r <= ST_DIVIDE;
          end
        end
        ST_NEXT: begin
          total_r <= '0;
          black_r <= '0;
          sum_x_r <= '0;
          sum_y_r <= '0;
          if (centers_found == FW'(NUM_CENTERS)) begin
            centers_valid <= 1'b1;
            busy_out      <= 1'b0;
            state_r       <= ST_DONE;
          end else if (last_zone_s) begin
            centers_error <= 1'b1;
            busy_out      <= 1'b0;
            state_r       <= ST_DONE;
          end else begin
            zx_r     <= nzx_s;
            zy_r     <= nzy_s;
            x_r      <= nx_lo_s;
            y_r      <= ny_lo_s;
            addr_out <= addr_of(nx_lo_s, ny_lo_s);
            state_r  <= ST_SCAN;
          end
        end
        ST_DONE: begin
          centers_valid <= 1'b0;
          centers_error <= 1'b0;
          state_r       <= ST_IDLE;
        end
        default: begin
          busy_out <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cross_centers_grid.sv
// Scoreboard bench for cross_centers_grid on a 24x24 frame with a 4-cycle BRAM model.
module tb_cross_centers_grid;

  localparam int W  = 24;
  localparam int H  = 24;
  localparam int RL = 4;

  logic        clk_in;
  logic        rst_n_in;
  logic        start_in;
  logic [23:0] horz_patterns;
  logic [23:0] vert_patterns;
  logic [9:0]  bound_x;
  logic [9:0]  bound_y;
  logic        pixel_in;
  logic [9:0]  addr_out;
  logic [14:0] centers_x;
  logic [14:0] centers_y;
  logic [1:0]  centers_found;
  logic        centers_valid;
  logic        centers_error;
  logic        busy_out;

  logic        mem [0:W*H-1];
  logic [9:0]  pipe [0:RL-1];

  typedef struct {
    logic        is_valid;
    int          found;
    logic [14:0] cx;
    logic [14:0] cy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks;
  int   errors;
  int   cyc;
  int   hold;

  cross_centers_grid #(
    .WIDTH(W), .HEIGHT(H), .ZONES_X(3), .ZONES_Y(3), .NUM_CENTERS(3),
    .READ_LATENCY(RL), .THRESH_NUM(3), .THRESH_SHIFT(2)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in),
    .horz_patterns(horz_patterns), .vert_patterns(vert_patterns),
    .bound_x(bound_x), .bound_y(bound_y), .pixel_in(pixel_in),
    .addr_out(addr_out), .centers_x(centers_x), .centers_y(centers_y),
    .centers_found(centers_found), .centers_valid(centers_valid),
    .centers_error(centers_error), .busy_out(busy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // BRAM model: data for an address appears RL cycles after it is presented.
  always @(posedge clk_in) begin
    pipe[0] <= addr_out;
    for (int k = 1; k < RL; k++) pipe[k] <= pipe[k-1];
  end
  assign pixel_in = mem[pipe[RL-1]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] pack3(input int a, input int b, input int c);
    pack3 = {5'(c), 5'(b), 5'(a)};
  endfunction

  task automatic expect_result(input logic v, input int f, input logic [14:0] cx, input logic [14:0] cy);
    exp_t e;
    e.is_valid = v;
    e.found    = f;
    e.cx       = cx;
    e.cy       = cy;
    exp_q.push_back(e);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"},  32'(busy_out), 32'd0);
    check({tag, "_addr"},  32'(addr_out), 32'd0);
    check({tag, "_found"}, 32'(centers_found), 32'd0);
    check({tag, "_cx"},    32'(centers_x), 32'd0);
    check({tag, "_cy"},    32'(centers_y), 32'd0);
    check({tag, "_valid"}, 32'(centers_valid), 32'd0);
    check({tag, "_error"}, 32'(centers_error), 32'd0);
  endtask

  task automatic fill_mem(input logic v);
    for (int i = 0; i < W*H; i++) mem[i] = v;
  endtask

  task automatic set_px(input int x, input int y, input logic v);
    mem[y*W + x] = v;
  endtask

  task automatic setup_main(input logic zone20_black);
    horz_patterns = '0;
    vert_patterns = '0;
    for (int i = 1; i <= 3; i++) begin
      horz_patterns[i] = 1'b1; horz_patterns[i+17] = 1'b1;
      vert_patterns[i] = 1'b1; vert_patterns[i+17] = 1'b1;
    end
    fill_mem(1'b0);
    for (int x = 18; x <= 20; x++)
      for (int y = 18; y <= 20; y++) set_px(x, y, 1'b1);
    if (!zone20_black)
      for (int x = 18; x <= 20; x++)
        for (int y = 1; y <= 3; y++) set_px(x, y, 1'b1);
  endtask

  // Starts a run and counts busy cycles; optionally pulses start or reset mid-run.
  task automatic run_dut(input int inject_at, input int reset_at, input logic [9:0] tgt,
                         output int n_busy, output int n_hold);
    int n;
    int run;
    n = 0; run = 0; n_busy = 0; n_hold = 0;
    @(negedge clk_in) start_in = 1'b1;
    @(negedge clk_in) start_in = 1'b0;
    while (!(centers_valid || centers_error) && n < 4000) begin
      if (busy_out) n_busy++;
      if (busy_out && addr_out == tgt) begin
        run++;
        if (run > n_hold) n_hold = run;
      end else begin
        run = 0;
      end
      start_in = (n_busy == inject_at);
      if (reset_at > 0 && n_busy == reset_at) begin
        check("found_before_reset", 32'(centers_found), 32'd1);
        rst_n_in = 1'b0;
        start_in = 1'b1;
        @(negedge clk_in);
        check_cleared("midrun_reset");
        rst_n_in = 1'b1;
        start_in = 1'b0;
        return;
      end
      n++;
      @(negedge clk_in);
    end
    start_in = 1'b0;
    if (n >= 4000) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got %0d cycles without a pulse, required fewer than 4000", n);
    end
  endtask

  // Monitor: every result pulse is matched against the oldest expectation.
  always @(negedge clk_in) begin
    if (centers_valid || centers_error) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got valid=%0b error=%0b, required no pulse", centers_valid, centers_error);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_kind", 32'({centers_valid, centers_error}), mon_e.is_valid ? 32'd2 : 32'd1);
        check("found",      32'(centers_found), 32'(mon_e.found));
        check("centers_x",  32'(centers_x), 32'(mon_e.cx));
        check("centers_y",  32'(centers_y), 32'(mon_e.cy));
        check("busy_at_pulse", 32'(busy_out), 32'd0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0;
    rst_n_in = 1'b0; start_in = 1'b0;
    bound_x = {5'd16, 5'd8};
    bound_y = {5'd16, 5'd8};
    for (int k = 0; k < RL; k++) pipe[k] = '0;
    setup_main(1'b1);
    repeat (3) @(negedge clk_in);
    check_cleared("reset");
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // Three qualifying zones, finishes at zone (0,2).
    expect_result(1'b1, 3, pack3(2, 19, 2), pack3(2, 2, 19));
    run_dut(-1, 0, 10'd0, cyc, hold);
    check("cycles_main", 32'(cyc), 32'd687);
    repeat (2) @(negedge clk_in);

    // start pulse while busy is ignored.
    expect_result(1'b1, 3, pack3(2, 19, 2), pack3(2, 2, 19));
    run_dut(200, 0, 10'd0, cyc, hold);
    check("cycles_busy_start", 32'(cyc), 32'd687);
    repeat (2) @(negedge clk_in);

    // Reset during the second divide, then a clean rerun.
    run_dut(-1, 330, 10'd0, cyc, hold);
    repeat (3) @(negedge clk_in);
    check("idle_after_reset_busy", 32'(busy_out), 32'd0);
    expect_result(1'b1, 3, pack3(2, 19, 2), pack3(2, 2, 19));
    run_dut(-1, 0, 10'd0, cyc, hold);
    check("cycles_after_reset", 32'(cyc), 32'd687);
    repeat (2) @(negedge clk_in);

    // Only two black zones: error, slot 2 stays zero.
    setup_main(1'b0);
    expect_result(1'b0, 2, pack3(2, 2, 0), pack3(2, 19, 0));
    run_dut(-1, 0, 10'd0, cyc, hold);
    check("cycles_two_zones", 32'(cyc), 32'd834);
    repeat (2) @(negedge clk_in);

    // Ratio boundary: 3 of 4 black gives 12 > 12 false.
    horz_patterns = 24'h000006;
    vert_patterns = 24'h000006;
    fill_mem(1'b1);
    set_px(1, 1, 1'b0); set_px(2, 1, 1'b0); set_px(1, 2, 1'b0);
    expect_result(1'b0, 0, 15'd0, 15'd0);
    run_dut(-1, 0, 10'd0, cyc, hold);
    check("cycles_ratio_reject", 32'(cyc), 32'd614);
    repeat (2) @(negedge clk_in);

    // 4 of 4 black qualifies; centroid 6/4 floors to 1.
    set_px(2, 2, 1'b0);
    expect_result(1'b0, 1, pack3(1, 0, 0), pack3(1, 0, 0));
    run_dut(-1, 0, 10'd0, cyc, hold);
    check("cycles_ratio_accept", 32'(cyc), 32'd644);
    repeat (2) @(negedge clk_in);

    // Single black candidate at address 25; neighbours white expose mistimed sampling.
    horz_patterns = 24'h000002;
    vert_patterns = 24'h000002;
    fill_mem(1'b1);
    set_px(1, 1, 1'b0);
    expect_result(1'b0, 1, pack3(1, 0, 0), pack3(1, 0, 0));
    run_dut(-1, 0, 10'd25, cyc, hold);
    check("cycles_latency", 32'(cyc), 32'd629);
    check("addr_hold_cycles", 32'(hold), 32'd6);
    repeat (3) @(negedge clk_in);

    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
